nf10_port_map_output_port_lookup: RTL and testbench

Parametrised output-port-lookup stage for the NetFPGA-10G router datapath, sitting between the input arbiter and the output queues. It maps each packet's one-hot source port to a destination port field in TUSER, using a runtime-writable per-port map table or a fixed NIC mode. Packets with no valid destination are dropped cleanly. Per-class packet counters (ARP, IPv4, OSPF, dropped) are exported.

---
 rtl/nf10_port_map_output_port_lookup_if.sv | 14 +
 rtl/nf10_port_map_output_port_lookup.sv | 137 +++++++++++++
 tb/tb_nf10_port_map_output_port_lookup.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nf10_port_map_output_port_lookup_if.sv
// nf10_port_map_output_port_lookup_if: AXI4-Stream bundle used on both sides of the lookup stage.
interface nf10_port_map_output_port_lookup_if #(
    parameter int DATA_WIDTH  = 256,
    parameter int TUSER_WIDTH = 128
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic [TUSER_WIDTH-1:0]  tuser;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;
    modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/nf10_port_map_output_port_lookup.sv
// nf10_port_map_output_port_lookup: rewrites the TUSER destination field from the one-hot source port
// using a writable map table (or fixed NIC pairing); packets without a destination are dropped.
module nf10_port_map_output_port_lookup #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_PORTS            = 4,
    parameter int SRC_PORT_POS         = 16,
    parameter int DST_PORT_POS         = 24,
    parameter int FIFO_DEPTH_BITS      = 2,
    parameter int MODE                 = 0,
    localparam int PW = 2 * NUM_PORTS,
    localparam int AW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1
) (
    input  logic          AXI_ACLK,
    input  logic          AXI_RESETN,
    nf10_port_map_output_port_lookup_if.slave  s_axis,
    nf10_port_map_output_port_lookup_if.master m_axis,
    input  logic          MAP_WR_EN,
    input  logic [AW-1:0] MAP_WR_ADDR,
    input  logic [PW-1:0] MAP_WR_DATA,
    output logic [31:0]   ARP_COUNT,
    output logic [31:0]   IPV4_COUNT,
    output logic [31:0]   OSPF_COUNT,
    output logic [31:0]   DROP_COUNT
);
    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;
    localparam int EW = 1 + UW + DW / 8 + DW;
    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam int CW = FIFO_DEPTH_BITS + 1;
    localparam logic [1:0] HEADER = 2'd0, FORWARD = 2'd1, DROP = 2'd2;
    localparam logic [PW-1:0] ONE = PW'(1);

    logic [EW-1:0]              mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]              count;
    logic                       ready_en, empty, nearly_full, wr, rd;
    logic [DW-1:0]              head_data;
    logic [DW/8-1:0]            head_strb;
    logic [UW-1:0]              head_user, out_user;
    logic                       head_last;
    logic [1:0]                 state, state_nxt;
    logic [PW-1:0]              map [NUM_PORTS];
    logic [PW-1:0]              src, dst;
    logic                       src_onehot, hs, hdr_fwd, hdr_drop, is_ip;

    // TREADY stays low until the first clock after reset release
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN)
        if (!AXI_RESETN) ready_en <= 1'b0;
        else ready_en <= 1'b1;

    assign empty         = count == '0;
    assign nearly_full   = count >= CW'(DEPTH - 1);
    assign s_axis.tready = ready_en & !nearly_full;
    assign wr            = s_axis.tvalid & s_axis.tready;
    assign {head_last, head_user, head_strb, head_data} = mem[rd_ptr];

    always_ff @(posedge AXI_ACLK)
        if (wr) mem[wr_ptr] <= {s_axis.tlast, s_axis.tuser, s_axis.tstrb, s_axis.tdata};

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + FIFO_DEPTH_BITS'(wr);
            rd_ptr <= rd_ptr + FIFO_DEPTH_BITS'(rd);
            count  <= count + CW'(wr) - CW'(rd);
        end
    end

    assign src        = head_user[SRC_PORT_POS +: PW];
    assign src_onehot = (src != '0) && ((src & (src - ONE)) == '0);

    // even bit = MAC k, odd bit = CPU k; CPU traffic always returns to its own MAC
    always_comb begin
        dst = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (src[2*k+1]) dst = ONE << (2 * k);
            if (src[2*k]) dst = (MODE != 0) ? ONE << (2 * k + 1) : map[k];
        end
        if (!src_onehot) dst = '0;
    end

    always_comb begin
        out_user = head_user;
        if (state == HEADER) out_user[DST_PORT_POS +: PW] = dst;
    end

    assign m_axis.tvalid = !empty & ((state == FORWARD) | ((state == HEADER) & (dst != '0)));
    assign m_axis.tdata  = C_M_AXIS_DATA_WIDTH'(head_data);
    assign m_axis.tstrb  = (C_M_AXIS_DATA_WIDTH / 8)'(head_strb);
    assign m_axis.tuser  = C_M_AXIS_TUSER_WIDTH'(out_user);
    assign m_axis.tlast  = head_last;

    assign hs       = m_axis.tvalid & m_axis.tready;
    assign hdr_fwd  = (state == HEADER) & hs;
    assign hdr_drop = (state == HEADER) & !empty & (dst == '0);
    assign rd       = hs | hdr_drop | ((state == DROP) & !empty);

    // a dropped header is popped immediately; the rest of the packet is drained in DROP
    assign state_nxt = hdr_drop ? (head_last ? HEADER : DROP) :
                       hs ? (head_last ? HEADER : FORWARD) :
                       ((state == DROP) && !empty && head_last) ? HEADER : state;

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN)
        if (!AXI_RESETN) state <= HEADER;
        else state <= state_nxt;

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            for (int k = 0; k < NUM_PORTS; k++)
                map[k] <= ((k ^ 1) < NUM_PORTS) ? ONE << (2 * (k ^ 1)) : '0;
        end else if (MAP_WR_EN) begin
            map[MAP_WR_ADDR] <= MAP_WR_DATA;
        end
    end

    assign is_ip = head_data[159:144] == 16'h0800;

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            ARP_COUNT  <= '0;
            IPV4_COUNT <= '0;
            OSPF_COUNT <= '0;
            DROP_COUNT <= '0;
        end else begin
            if (hdr_drop) DROP_COUNT <= DROP_COUNT + 32'd1;
            if (hdr_fwd && head_data[159:144] == 16'h0806) ARP_COUNT <= ARP_COUNT + 32'd1;
            if (hdr_fwd && is_ip && head_data[143:140] == 4'd4) IPV4_COUNT <= IPV4_COUNT + 32'd1;
            if (hdr_fwd && is_ip && head_data[71:64] == 8'd89) OSPF_COUNT <= OSPF_COUNT + 32'd1;
        end
    end
endmodule

// File: tb/tb_nf10_port_map_output_port_lookup.sv
// tb_nf10_port_map_output_port_lookup: directed checks of port mapping, drops, counters,
// backpressure and mid-packet reset.
`timescale 1ns/1ps
module tb_nf10_port_map_output_port_lookup;
    logic        AXI_ACLK = 1'b0;
    logic        AXI_RESETN = 1'b1;
    logic        MAP_WR_EN = 1'b0;
    logic [1:0]  MAP_WR_ADDR = '0;
    logic [7:0]  MAP_WR_DATA = '0;
    logic [31:0] ARP_COUNT, IPV4_COUNT, OSPF_COUNT, DROP_COUNT;
    logic [31:0] e_arp = 0, e_ipv4 = 0, e_ospf = 0, e_drop = 0;

    nf10_port_map_output_port_lookup_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) s_if ();
    nf10_port_map_output_port_lookup_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) m_if ();

    nf10_port_map_output_port_lookup dut (
        .AXI_ACLK(AXI_ACLK), .AXI_RESETN(AXI_RESETN),
        .s_axis(s_if), .m_axis(m_if),
        .MAP_WR_EN(MAP_WR_EN), .MAP_WR_ADDR(MAP_WR_ADDR), .MAP_WR_DATA(MAP_WR_DATA),
        .ARP_COUNT(ARP_COUNT), .IPV4_COUNT(IPV4_COUNT), .OSPF_COUNT(OSPF_COUNT), .DROP_COUNT(DROP_COUNT)
    );

    always #5 AXI_ACLK = ~AXI_ACLK;

    int checks = 0, errors = 0;
    int rdy_mode = 0;
    int unstable = 0;
    logic stalled = 1'b0;
    logic [255:0] last_d;
    logic [127:0] last_u;
    logic [255:0] out_d[$], exp_d[$];
    logic [127:0] out_u[$], exp_u[$];
    logic         out_l[$], exp_l[$];

    // output sink: 0 = always ready, 1 = random backpressure, 2 = never ready
    always @(negedge AXI_ACLK) begin
        m_if.tready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
        #1;
        if (stalled && (!m_if.tvalid || m_if.tdata !== last_d || m_if.tuser !== last_u)) unstable++;
        stalled = m_if.tvalid && !m_if.tready;
        last_d = m_if.tdata;
        last_u = m_if.tuser;
        if (m_if.tvalid && m_if.tready) begin
            out_d.push_back(m_if.tdata);
            out_u.push_back(m_if.tuser);
            out_l.push_back(m_if.tlast);
        end
    end

    function automatic logic [255:0] mk_data(int tag, int b, logic [15:0] et, logic [3:0] ver, logic [7:0] pr);
        logic [255:0] d;
        d = {8{tag[15:0], b[15:0]}};
        if (b == 0) begin
            d[159:144] = et;
            d[143:140] = ver;
            d[71:64] = pr;
        end
        return d;
    endfunction

    function automatic logic [127:0] mk_user(int tag, int b, logic [7:0] src);
        logic [127:0] u;
        u = {4{tag[15:0], b[15:0]}};
        u[23:16] = src;
        u[31:24] = 8'hA5;
        return u;
    endfunction

    task automatic send_beat(input logic [255:0] d, input logic [127:0] u, input logic l);
        int n;
        s_if.tdata = d;
        s_if.tuser = u;
        s_if.tlast = l;
        s_if.tstrb = '1;
        s_if.tvalid = 1'b1;
        n = 0;
        while (!s_if.tready && n < 1000) begin
            @(negedge AXI_ACLK);
            n++;
        end
        if (n == 1000) begin
            checks++;
            errors++;
            $display("FAIL send_timeout tready=%b required 1", s_if.tready);
        end
        @(negedge AXI_ACLK);
    endtask

    task automatic send_pkt(input int tag, input int n, input logic [7:0] src, input logic [15:0] et,
                            input logic [3:0] ver, input logic [7:0] pr);
        for (int b = 0; b < n; b++) send_beat(mk_data(tag, b, et, ver, pr), mk_user(tag, b, src), b == n - 1);
        s_if.tvalid = 1'b0;
    endtask

    task automatic expect_pkt(input int tag, input int n, input logic [7:0] src, input logic [7:0] dst,
                              input logic [15:0] et, input logic [3:0] ver, input logic [7:0] pr);
        logic [127:0] u;
        for (int b = 0; b < n; b++) begin
            u = mk_user(tag, b, src);
            if (b == 0) u[31:24] = dst;
            exp_d.push_back(mk_data(tag, b, et, ver, pr));
            exp_u.push_back(u);
            exp_l.push_back(b == n - 1);
        end
    endtask

    task automatic clear_q;
        out_d.delete(); out_u.delete(); out_l.delete();
        exp_d.delete(); exp_u.delete(); exp_l.delete();
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (out_d.size() < exp_d.size() && n < 3000) begin
            @(negedge AXI_ACLK);
            n++;
        end
        repeat (8) @(negedge AXI_ACLK);
    endtask

    task automatic map_write(input logic [1:0] a, input logic [7:0] d);
        MAP_WR_EN = 1'b1;
        MAP_WR_ADDR = a;
        MAP_WR_DATA = d;
        @(negedge AXI_ACLK);
        MAP_WR_EN = 1'b0;
    endtask

    task automatic test_reset;
        s_if.tvalid = 1'b0;
        #1 AXI_RESETN = 1'b0;
        repeat (3) @(negedge AXI_ACLK);
        checks++;
        if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_if.tvalid); end
        checks++;
        if (s_if.tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b want 0", s_if.tready); end
        AXI_RESETN = 1'b1;
        #1;
        checks++;
        if (s_if.tready !== 1'b0) begin errors++; $display("FAIL release_tready_early got %b want 0", s_if.tready); end
        @(negedge AXI_ACLK);
        checks++;
        if (s_if.tready !== 1'b1) begin errors++; $display("FAIL release_tready got %b want 1", s_if.tready); end
        checks++;
        if ({ARP_COUNT, IPV4_COUNT, OSPF_COUNT, DROP_COUNT} !== 128'd0) begin
            errors++;
            $display("FAIL reset_counters got %h want 0", {ARP_COUNT, IPV4_COUNT, OSPF_COUNT, DROP_COUNT});
        end
    endtask

    task automatic check_beats(input string name);
        checks++;
        if (out_d.size() != exp_d.size()) begin
            errors++;
            $display("FAIL %s beat_count got %0d want %0d", name, out_d.size(), exp_d.size());
        end
        foreach (exp_d[i]) begin
            checks++;
            if (i >= out_d.size() || out_d[i] !== exp_d[i] || out_u[i] !== exp_u[i] || out_l[i] !== exp_l[i]) begin
                errors++;
                if (i < out_d.size())
                    $display("FAIL %s beat %0d got user=%h last=%b data=%h want user=%h last=%b data=%h",
                             name, i, out_u[i], out_l[i], out_d[i], exp_u[i], exp_l[i], exp_d[i]);
                else
                    $display("FAIL %s beat %0d got none want user=%h", name, i, exp_u[i]);
            end
        end
    endtask

    task automatic test_default_map;
        clear_q();
        expect_pkt(1, 3, 8'h01, 8'h04, 16'h0800, 4'd4, 8'd6);
        send_pkt(1, 3, 8'h01, 16'h0800, 4'd4, 8'd6);
        drain();
        e_ipv4 = 1;
        check_beats("default_map");
        checks++;
        if ({ARP_COUNT, IPV4_COUNT, OSPF_COUNT, DROP_COUNT} !== {e_arp, e_ipv4, e_ospf, e_drop}) begin
            errors++;
            $display("FAIL default_counters got %h want %h", {ARP_COUNT, IPV4_COUNT, OSPF_COUNT, DROP_COUNT},
                     {e_arp, e_ipv4, e_ospf, e_drop});
        end
    endtask

    task automatic test_map_write;
        clear_q();
        map_write(2'd0, 8'h40);
        expect_pkt(2, 2, 8'h01, 8'h40, 16'h88B5, 4'd0, 8'd0);
        expect_pkt(3, 3, 8'h02, 8'h01, 16'h88B5, 4'd0, 8'd0);
        send_pkt(2, 2, 8'h01, 16'h88B5, 4'd0, 8'd0);
        send_pkt(3, 3, 8'h02, 16'h88B5, 4'd0, 8'd0);
        drain();
        check_beats("map_write");
    endtask

    task automatic test_drop;
        clear_q();
        map_write(2'd2, 8'h00);
        expect_pkt(5, 2, 8'h40, 8'h10, 16'h88B5, 4'd0, 8'd0);
        send_pkt(4, 4, 8'h10, 16'h0800, 4'd4, 8'd89);
        send_pkt(5, 2, 8'h40, 16'h88B5, 4'd0, 8'd0);
        drain();
        e_drop = 1;
        check_beats("drop");
        checks++;
        if ({ARP_COUNT, IPV4_COUNT, OSPF_COUNT, DROP_COUNT} !== {e_arp, e_ipv4, e_ospf, e_drop}) begin
            errors++;
            $display("FAIL drop_counters got %h want %h", {ARP_COUNT, IPV4_COUNT, OSPF_COUNT, DROP_COUNT},
                     {e_arp, e_ipv4, e_ospf, e_drop});
        end
    endtask

    task automatic test_classes;
        clear_q();
        expect_pkt(6, 1, 8'h01, 8'h40, 16'h0806, 4'd0, 8'd0);
        expect_pkt(7, 2, 8'h80, 8'h40, 16'h0800, 4'd4, 8'd89);
        expect_pkt(9, 2, 8'h08, 8'h04, 16'h0800, 4'd6, 8'd89);
        send_pkt(6, 1, 8'h01, 16'h0806, 4'd0, 8'd0);
        send_pkt(7, 2, 8'h80, 16'h0800, 4'd4, 8'd89);
        send_pkt(8, 2, 8'h03, 16'h0800, 4'd4, 8'd6);
        send_pkt(9, 2, 8'h08, 16'h0800, 4'd6, 8'd89);
        drain();
        e_arp = 1;
        e_ipv4 = 2;
        e_ospf = 2;
        e_drop = 2;
        check_beats("classes");
        checks++;
        if ({ARP_COUNT, IPV4_COUNT, OSPF_COUNT, DROP_COUNT} !== {e_arp, e_ipv4, e_ospf, e_drop}) begin
            errors++;
            $display("FAIL class_counters got %h want %h", {ARP_COUNT, IPV4_COUNT, OSPF_COUNT, DROP_COUNT},
                     {e_arp, e_ipv4, e_ospf, e_drop});
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] srcs [5];
        logic [7:0] dsts [5];
        int len, sel;
        srcs = '{8'h01, 8'h02, 8'h08, 8'h40, 8'h20};
        dsts = '{8'h40, 8'h01, 8'h04, 8'h10, 8'h10};
        clear_q();
        unstable = 0;
        rdy_mode = 1;
        for (int p = 0; p < 100; p++) begin
            len = $urandom_range(1, 4);
            sel = p % 5;
            expect_pkt(100 + p, len, srcs[sel], dsts[sel], 16'h9000, 4'd0, 8'd0);
            send_pkt(100 + p, len, srcs[sel], 16'h9000, 4'd0, 8'd0);
        end
        drain();
        rdy_mode = 0;
        repeat (2) @(negedge AXI_ACLK);
        check_beats("back_to_back");
        checks++;
        if (unstable !== 0) begin errors++; $display("FAIL stall_stability got %0d changes want 0", unstable); end
        checks++;
        if ({ARP_COUNT, IPV4_COUNT, OSPF_COUNT, DROP_COUNT} !== {e_arp, e_ipv4, e_ospf, e_drop}) begin
            errors++;
            $display("FAIL b2b_counters got %h want %h", {ARP_COUNT, IPV4_COUNT, OSPF_COUNT, DROP_COUNT},
                     {e_arp, e_ipv4, e_ospf, e_drop});
        end
    endtask

    task automatic test_reset_mid;
        clear_q();
        rdy_mode = 2;
        send_beat(mk_data(200, 0, 16'h0800, 4'd4, 8'd6), mk_user(200, 0, 8'h01), 1'b0);
        send_beat(mk_data(200, 1, 16'h0800, 4'd4, 8'd6), mk_user(200, 1, 8'h01), 1'b0);
        s_if.tvalid = 1'b0;
        repeat (2) @(negedge AXI_ACLK);
        checks++;
        if (m_if.tvalid !== 1'b1 || m_if.tuser[31:24] !== 8'h40) begin
            errors++;
            $display("FAIL stalled_header got valid=%b dst=%h want valid=1 dst=40", m_if.tvalid, m_if.tuser[31:24]);
        end
        AXI_RESETN = 1'b0;
        #1;
        checks++;
        if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL mid_reset_tvalid got %b want 0", m_if.tvalid); end
        checks++;
        if ({ARP_COUNT, IPV4_COUNT, OSPF_COUNT, DROP_COUNT} !== 128'd0) begin
            errors++;
            $display("FAIL mid_reset_counters got %h want 0", {ARP_COUNT, IPV4_COUNT, OSPF_COUNT, DROP_COUNT});
        end
        repeat (2) @(negedge AXI_ACLK);
        AXI_RESETN = 1'b1;
        rdy_mode = 0;
        @(negedge AXI_ACLK);
        e_arp = 0;
        e_ipv4 = 1;
        e_ospf = 0;
        e_drop = 0;
        expect_pkt(201, 3, 8'h01, 8'h04, 16'h0800, 4'd4, 8'd6);
        send_pkt(201, 3, 8'h01, 16'h0800, 4'd4, 8'd6);
        drain();
        check_beats("after_reset");
        checks++;
        if ({ARP_COUNT, IPV4_COUNT, OSPF_COUNT, DROP_COUNT} !== {e_arp, e_ipv4, e_ospf, e_drop}) begin
            errors++;
            $display("FAIL post_reset_counters got %h want %h", {ARP_COUNT, IPV4_COUNT, OSPF_COUNT, DROP_COUNT},
                     {e_arp, e_ipv4, e_ospf, e_drop});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_default_map();
        test_map_write();
        test_drop();
        test_classes();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
